// File: rtl/jx2_wb_pkg.sv
// Shared definitions for the lane-3+ writeback deferral stage.
package jx2_wb_pkg;

  localparam int unsigned JX2_GPR_ID_W  = 7;
  localparam int unsigned JX2_GPR_VAL_W = 64;

  localparam logic [JX2_GPR_ID_W-1:0] ZZR_ID = 7'h3F;

  localparam logic [15:0] STALL_CNT_MAX = 16'hFFFF;

  typedef struct packed {
    logic [JX2_GPR_ID_W-1:0]  id;
    logic [JX2_GPR_VAL_W-1:0] val;
  } wb_entry_t;

  localparam wb_entry_t WB_ENTRY_NULL = '{id: ZZR_ID, val: '0};

endpackage

// File: rtl/wb_fifo2.sv
// Two-entry in-order result buffer; both slots are exposed for forwarding.
module wb_fifo2
  import jx2_wb_pkg::*;
(
  input  logic      clock,
  input  logic      reset,
  input  logic      push,
  input  wb_entry_t push_entry,
  input  logic      pop,
  output wb_entry_t head_entry,
  output wb_entry_t ent0,
  output wb_entry_t ent1,
  output logic      head_ptr,
  output logic      tail_ptr,
  output logic [1:0] count
);

  wb_entry_t  mem_q [2];
  logic       head_q;
  logic       tail_q;
  logic [1:0] count_q;
  logic [1:0] count_d;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Slots reset to the null entry so the head reads ZZR_ID/0 after reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_q[0] <= WB_ENTRY_NULL;
      mem_q[1] <= WB_ENTRY_NULL;
      head_q   <= 1'b0;
      tail_q   <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[tail_q] <= push_entry;
        tail_q        <= ~tail_q;
      end
      if (pop) begin
        head_q <= ~head_q;
      end
      count_q <= count_d;
    end
  end

  assign head_entry = mem_q[head_q];
  assign ent0       = mem_q[0];
  assign ent1       = mem_q[1];
  assign head_ptr   = head_q;
  assign tail_ptr   = tail_q;
  assign count      = count_q;

endmodule

// File: rtl/exwb_defer_c3.sv
// Writeback deferral stage for execute lane 3+: hold/space logic, forwarding, stall counter.
// Optional forwarding compare is enabled by defining JX2_WBDEFER_FWD_EN.
module exwb_defer_c3
  import jx2_wb_pkg::*;
#(
  parameter int unsigned     GPR_ID_W  = JX2_GPR_ID_W,
  parameter int unsigned     GPR_VAL_W = JX2_GPR_VAL_W,
  parameter logic [6:0]      ZZR_ID    = jx2_wb_pkg::ZZR_ID
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [GPR_ID_W-1:0]  regIdRn4,
  input  logic [GPR_VAL_W-1:0] regValRn4,
  input  logic                 exHoldIn,
  output logic                 wbValid,
  output logic [GPR_ID_W-1:0]  wbId,
  output logic [GPR_VAL_W-1:0] wbVal,
  input  logic                 wbReady,
  output logic                 holdOut,
  input  logic [GPR_ID_W-1:0]  fwdId,
  output logic                 fwdHit,
  output logic [GPR_VAL_W-1:0] fwdVal,
  output logic [15:0]          wbStallCnt
);

  logic       push;
  logic       pop;
  logic       space;
  logic       head_ptr;
  logic       tail_ptr;
  logic [1:0] count;
  wb_entry_t  push_entry;
  wb_entry_t  head_entry;
  wb_entry_t  ent0;
  wb_entry_t  ent1;
  logic [15:0] stall_cnt_q;

  assign wbValid = (count != 2'd0);
  assign pop     = wbValid && wbReady;
  // A full buffer still has room when the head leaves this same cycle.
  assign space   = (count < 2'd2) || pop;
  assign holdOut = !space;
  assign push    = !exHoldIn && space && (regIdRn4 != ZZR_ID);

  assign push_entry.id  = regIdRn4;
  assign push_entry.val = regValRn4;

  wb_fifo2 u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head_entry (head_entry),
    .ent0       (ent0),
    .ent1       (ent1),
    .head_ptr   (head_ptr),
    .tail_ptr   (tail_ptr),
    .count      (count)
  );

  assign wbId  = head_entry.id;
  assign wbVal = head_entry.val;

`ifdef JX2_WBDEFER_FWD_EN
  wb_entry_t newest;
  wb_entry_t oldest;

  always_comb begin
    newest = tail_ptr ? ent0 : ent1;
    oldest = head_ptr ? ent1 : ent0;
    fwdHit = 1'b0;
    fwdVal = '0;
    // Newest entry (tail-1) wins; the head only matters when both are pending.
    if (fwdId != ZZR_ID) begin
      if ((count != 2'd0) && (newest.id == fwdId)) begin
        fwdHit = 1'b1;
        fwdVal = newest.val;
      end else if ((count == 2'd2) && (oldest.id == fwdId)) begin
        fwdHit = 1'b1;
        fwdVal = oldest.val;
      end
    end
  end
`else
  logic fwd_unused;

  assign fwd_unused = ^{fwdId, head_ptr, ent0, ent1};
  assign fwdHit     = 1'b0;
  assign fwdVal     = '0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= 16'd0;
    end else if (holdOut && (stall_cnt_q != STALL_CNT_MAX)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign wbStallCnt = stall_cnt_q;

endmodule

// File: tb/tb_exwb_defer_c3.sv
// Scoreboard bench for exwb_defer_c3: driver queues expected writebacks, monitor checks transfers.
module tb_exwb_defer_c3;

  logic        clock;
  logic        reset;
  logic [6:0]  regIdRn4;
  logic [63:0] regValRn4;
  logic        exHoldIn;
  logic        wbValid;
  logic [6:0]  wbId;
  logic [63:0] wbVal;
  logic        wbReady;
  logic        holdOut;
  logic [6:0]  fwdId;
  logic        fwdHit;
  logic [63:0] fwdVal;
  logic [15:0] wbStallCnt;

  int checks = 0;
  int errors = 0;

  logic [70:0] exp_q [$];

`ifdef JX2_WBDEFER_FWD_EN
  localparam logic FWD_ON = 1'b1;
`else
  localparam logic FWD_ON = 1'b0;
`endif

  exwb_defer_c3 dut (
    .clock      (clock),
    .reset      (reset),
    .regIdRn4   (regIdRn4),
    .regValRn4  (regValRn4),
    .exHoldIn   (exHoldIn),
    .wbValid    (wbValid),
    .wbId       (wbId),
    .wbVal      (wbVal),
    .wbReady    (wbReady),
    .holdOut    (holdOut),
    .fwdId      (fwdId),
    .fwdHit     (fwdHit),
    .fwdVal     (fwdVal),
    .wbStallCnt (wbStallCnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic present(input logic [6:0] id, input logic [63:0] val, input logic expect_wb);
    regIdRn4  = id;
    regValRn4 = val;
    if (expect_wb) exp_q.push_back({id, val});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " wbValid"},    {63'd0, wbValid}, 64'd0);
    check({tag, " wbId"},       {57'd0, wbId}, 64'h3F);
    check({tag, " wbVal"},      wbVal, 64'd0);
    check({tag, " holdOut"},    {63'd0, holdOut}, 64'd0);
    check({tag, " fwdHit"},     {63'd0, fwdHit}, 64'd0);
    check({tag, " fwdVal"},     fwdVal, 64'd0);
    check({tag, " wbStallCnt"}, {48'd0, wbStallCnt}, 64'd0);
  endtask

  // Monitor: a transfer happens at the next rising edge when valid and ready.
  always @(negedge clock) begin
    if (!reset && wbValid && wbReady) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wb_unexpected: got id %0h val %0h expected no transfer", wbId, wbVal);
      end else begin
        logic [70:0] e;
        e = exp_q.pop_front();
        checks++;
        if ({wbId, wbVal} !== e) begin
          errors++;
          $display("FAIL wb_order: got id %0h val %0h expected id %0h val %0h",
                   wbId, wbVal, e[70:64], e[63:0]);
        end
      end
    end
  end

  initial begin
    reset     = 1'b1;
    regIdRn4  = 7'h3F;
    regValRn4 = 64'd0;
    exHoldIn  = 1'b0;
    wbReady   = 1'b0;
    fwdId     = 7'd0;
    #12;
    check_reset_outputs("reset");
    @(negedge clock);
    reset = 1'b0;
    tick();

    // Single result, immediately accepted.
    wbReady = 1'b1;
    present(7'd5, 64'h1234, 1'b1);
    tick();
    present(7'h3F, 64'd0, 1'b0);
    check("t1 wbValid", {63'd0, wbValid}, 64'd1);
    check("t1 wbId", {57'd0, wbId}, 64'd5);
    check("t1 wbVal", wbVal, 64'h1234);
    tick();
    check("t1 drained", {63'd0, wbValid}, 64'd0);

    // Fill with ready low, third result held, captured when ready rises.
    wbReady = 1'b0;
    present(7'd3, 64'h33, 1'b1);
    tick();
    present(7'd4, 64'h44, 1'b1);
    tick();
    present(7'd6, 64'h66, 1'b1);
    check("t2 hold full", {63'd0, holdOut}, 64'd1);
    tick();
    check("t2 hold kept", {63'd0, holdOut}, 64'd1);
    wbReady = 1'b1;
    #1;
    check("t2 hold released", {63'd0, holdOut}, 64'd0);
    tick();
    present(7'h3F, 64'd0, 1'b0);
    tick();
    tick();
    tick();
    check("t2 drained", {63'd0, wbValid}, 64'd0);
    check("t2 stall cnt", {48'd0, wbStallCnt}, 64'd1);

    // Null destination and pipeline hold capture nothing.
    present(7'h3F, 64'hFFFF, 1'b0);
    tick();
    check("t3 zzr valid", {63'd0, wbValid}, 64'd0);
    check("t3 zzr hold", {63'd0, holdOut}, 64'd0);
    exHoldIn = 1'b1;
    present(7'd9, 64'h99, 1'b0);
    tick();
    check("t3 exhold valid", {63'd0, wbValid}, 64'd0);
    exHoldIn = 1'b0;

    // Forwarding: newest matching entry wins.
    wbReady = 1'b0;
    present(7'd7, 64'hA, 1'b1);
    tick();
    present(7'd7, 64'hB, 1'b1);
    tick();
    present(7'h3F, 64'd0, 1'b0);
    fwdId = 7'd7;
    #1;
    check("t4 fwdHit", {63'd0, fwdHit}, {63'd0, FWD_ON});
    check("t4 fwdVal", fwdVal, FWD_ON ? 64'hB : 64'd0);
    fwdId = 7'h3F;
    #1;
    check("t4 fwd zzr", {63'd0, fwdHit}, 64'd0);
    fwdId = 7'd2;
    #1;
    check("t4 fwd miss", {63'd0, fwdHit}, 64'd0);
    check("t4 stall cnt", {48'd0, wbStallCnt}, 64'd1);

    // Full buffer with ready high: simultaneous dequeue and enqueue.
    wbReady = 1'b1;
    present(7'd8, 64'h88, 1'b1);
    #1;
    check("t5 no hold", {63'd0, holdOut}, 64'd0);
    tick();
    present(7'h3F, 64'd0, 1'b0);
    wbReady = 1'b0;
    fwdId = 7'd8;
    #1;
    check("t5 still full", {63'd0, holdOut}, 64'd1);
    check("t5 head 7B", wbVal, 64'hB);
    check("t5 fwdVal new", fwdVal, FWD_ON ? 64'h88 : 64'd0);
    wbReady = 1'b1;
    tick();
    tick();
    check("t5 drained", {63'd0, wbValid}, 64'd0);
    check("scoreboard empty", {32'd0, exp_q.size()}, 64'd0);

    // Long hold saturates the stall counter; reset mid-hold clears everything.
    wbReady = 1'b0;
    present(7'd10, 64'h10, 1'b0);
    tick();
    present(7'd11, 64'h11, 1'b0);
    tick();
    present(7'h3F, 64'd0, 1'b0);
    for (int i = 0; i < 70000; i++) tick();
    check("t6 stall sat", {48'd0, wbStallCnt}, 64'hFFFF);
    check("t6 hold", {63'd0, holdOut}, 64'd1);
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("t6 async reset");
    @(negedge clock);
    reset = 1'b0;
    tick();
    check("t6 post reset valid", {63'd0, wbValid}, 64'd0);
    check("t6 post reset stall", {48'd0, wbStallCnt}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
